fetch_unit: RTL and testbench

// Instruction-fetch stage. Sits directly upstream of ICache: generates the fetch PC on ICache Addr and

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues PCs to the ICache, queues returned words in a
// 2-entry FIFO and hands {pc, inst} to decode; handles redirects and in-flight kills.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] FetchAddr,
  input  logic [31:0] CacheInst,
  input  logic        CacheStall,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPc,
  output logic        IfValid,
  output logic [31:0] IfPc,
  output logic [31:0] IfInst,
  input  logic        DecodeReady
);

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        req_valid;
  logic        kill;
  logic [1:0]  count;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];

  logic        resp;
  logic        pop;
  logic        push;
  logic        issue;
  logic        kill_pend;
  logic [2:0]  occ;
  logic        wr_idx;

  assign resp      = req_valid & ~CacheStall;
  assign IfValid   = (count != 2'd0);
  assign pop       = IfValid & DecodeReady;
  assign push      = resp & ~kill & ~RedirectValid;
  assign kill_pend = kill & req_valid & CacheStall;

  // Occupancy after this cycle's reply and pop; a new issue needs a free slot for its reply.
  assign occ   = {1'b0, count} + {2'b00, resp & ~kill} - {2'b00, pop};
  assign issue = ~RedirectValid & ~CacheStall & ~kill_pend & (occ <= 3'd1);

  assign FetchAddr = issue ? pc : req_pc;
  assign IfPc      = IfValid ? fifo_pc[0]   : '0;
  assign IfInst    = IfValid ? fifo_inst[0] : '0;

  // Head is slot 0; a push lands behind whatever survives this cycle's pop.
  assign wr_idx = count[1] | (count[0] & ~pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
      kill      <= 1'b0;
    end else begin
      if (issue) begin
        req_pc    <= pc;
        req_valid <= 1'b1;
        pc        <= pc + 32'd4;
      end else if (RedirectValid) begin
        pc <= RedirectPc & ~32'd3;
        if (!CacheStall) req_valid <= 1'b0;
      end else if (resp) begin
        req_valid <= 1'b0;
      end
      // Kill survives further redirects until the stalled reply finally returns.
      kill <= (RedirectValid & req_valid & CacheStall) | (kill & ~resp);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
      fifo_inst[0] <= '0;
      fifo_inst[1] <= '0;
    end else if (RedirectValid) begin
      count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        fifo_pc[0]   <= fifo_pc[1];
        fifo_inst[0] <= fifo_inst[1];
      end
      if (push) begin
        fifo_pc[wr_idx]   <= req_pc;
        fifo_inst[wr_idx] <= CacheInst;
      end
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-cycle-latency ICache model answers the last
// accepted address; each task checks a scenario cycle by cycle at the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] FetchAddr;
  logic [31:0] CacheInst;
  logic        CacheStall;
  logic        RedirectValid;
  logic [31:0] RedirectPc;
  logic        IfValid;
  logic [31:0] IfPc;
  logic [31:0] IfInst;
  logic        DecodeReady;

  int checks = 0;
  int errors = 0;

  logic [31:0] cache_q = '0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .FetchAddr(FetchAddr), .CacheInst(CacheInst),
    .CacheStall(CacheStall), .RedirectValid(RedirectValid), .RedirectPc(RedirectPc),
    .IfValid(IfValid), .IfPc(IfPc), .IfInst(IfInst), .DecodeReady(DecodeReady)
  );

  always #5 clk = ~clk;

  // Cache model: word for the address presented at the previous edge.
  always @(posedge clk) cache_q <= FetchAddr;
  assign CacheInst = cache_q ^ 32'h5A5A_0000;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic do_reset();
    rst = 1'b0; RedirectValid = 1'b0; RedirectPc = '0; CacheStall = 1'b0; DecodeReady = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; RedirectValid = 1'b0; RedirectPc = '0; CacheStall = 1'b0; DecodeReady = 1'b1;
    @(negedge clk); #1;
    checks++; if (IfValid !== 1'b0) begin errors++; $display("FAIL reset_ifvalid got %h want 0", IfValid); end
    checks++; if (IfPc !== 32'h0) begin errors++; $display("FAIL reset_ifpc got %h want 0", IfPc); end
    checks++; if (IfInst !== 32'h0) begin errors++; $display("FAIL reset_ifinst got %h want 0", IfInst); end
    checks++; if (FetchAddr !== 32'h0) begin errors++; $display("FAIL reset_fetchaddr got %h want 0", FetchAddr); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (FetchAddr !== 32'(4 * k)) begin
        errors++; $display("FAIL stream_addr c%0d got %h want %h", k, FetchAddr, 32'(4 * k));
      end
      checks++;
      if (IfValid !== (k >= 2)) begin
        errors++; $display("FAIL stream_valid c%0d got %b want %b", k, IfValid, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (IfPc !== 32'(4 * (k - 2)) || IfInst !== word_of(32'(4 * (k - 2)))) begin
          errors++; $display("FAIL stream_head c%0d got %h/%h want %h", k, IfPc, IfInst, 32'(4 * (k - 2)));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      DecodeReady = !(k >= 2 && k <= 6);
      #1;
      if (k >= 3 && k <= 6) begin
        checks++;
        if (FetchAddr !== 32'h4 || IfPc !== 32'h0 || IfValid !== 1'b1) begin
          errors++; $display("FAIL bp_hold c%0d got addr %h pc %h v %b want 4/0/1", k, FetchAddr, IfPc, IfValid);
        end
      end
      if (k >= 7) begin
        checks++;
        if (IfPc !== 32'(4 * (k - 7)) || FetchAddr !== 32'(8 + 4 * (k - 7))) begin
          errors++; $display("FAIL bp_resume c%0d got pc %h addr %h want %h %h",
                             k, IfPc, FetchAddr, 32'(4 * (k - 7)), 32'(8 + 4 * (k - 7)));
        end
      end
      @(negedge clk);
    end
    DecodeReady = 1'b1;
  endtask

  task automatic test_miss();
    do_reset();
    for (int k = 0; k < 23; k++) begin
      CacheStall = (k >= 17 && k <= 19);
      #1;
      if (k >= 17 && k <= 19) begin
        checks++;
        if (FetchAddr !== 32'h40) begin
          errors++; $display("FAIL miss_hold c%0d got %h want 00000040", k, FetchAddr);
        end
      end
      if (k == 18 || k == 19) begin
        checks++;
        if (IfValid !== 1'b0) begin errors++; $display("FAIL miss_empty c%0d got %b want 0", k, IfValid); end
      end
      if (k == 20) begin
        checks++;
        if (FetchAddr !== 32'h44) begin errors++; $display("FAIL miss_next got %h want 00000044", FetchAddr); end
      end
      if (k == 21) begin
        checks++;
        if (IfValid !== 1'b1 || IfPc !== 32'h40 || IfInst !== word_of(32'h40)) begin
          errors++; $display("FAIL miss_head got %b %h %h want 1 00000040", IfValid, IfPc, IfInst);
        end
      end
      if (k == 22) begin
        checks++;
        if (IfPc !== 32'h44) begin errors++; $display("FAIL miss_after got %h want 00000044", IfPc); end
      end
      @(negedge clk);
    end
    CacheStall = 1'b0;
  endtask

  task automatic test_redirect_full();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      DecodeReady   = (k < 2);
      RedirectValid = (k == 3);
      RedirectPc    = 32'h103;
      #1;
      if (k == 3) begin
        checks++;
        if (IfValid !== 1'b1 || IfPc !== 32'h0) begin
          errors++; $display("FAIL redir_full_pre got %b %h want 1 0", IfValid, IfPc);
        end
      end
      if (k == 4) begin
        checks++;
        if (IfValid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", IfValid); end
        checks++;
        if (FetchAddr !== 32'h100) begin errors++; $display("FAIL redir_target got %h want 00000100", FetchAddr); end
      end
      if (k == 5) begin
        checks++;
        if (FetchAddr !== 32'h104 || IfValid !== 1'b0) begin
          errors++; $display("FAIL redir_next got %h %b want 00000104 0", FetchAddr, IfValid);
        end
      end
      if (k == 6) begin
        checks++;
        if (IfPc !== 32'h100 || IfInst !== word_of(32'h100)) begin
          errors++; $display("FAIL redir_head got %h %h want 00000100", IfPc, IfInst);
        end
      end
      @(negedge clk);
    end
    RedirectValid = 1'b0; DecodeReady = 1'b1;
  endtask

  task automatic test_redirect_kill();
    do_reset();
    for (int k = 0; k < 39; k++) begin
      CacheStall    = (k >= 33 && k <= 35);
      RedirectValid = (k == 33);
      RedirectPc    = 32'h200;
      #1;
      if (k >= 33 && k <= 35) begin
        checks++;
        if (FetchAddr !== 32'h80) begin errors++; $display("FAIL kill_hold c%0d got %h want 00000080", k, FetchAddr); end
      end
      if (k == 34) begin
        checks++;
        if (IfValid !== 1'b0) begin errors++; $display("FAIL kill_flush got %b want 0", IfValid); end
      end
      if (k == 36) begin
        checks++;
        if (FetchAddr !== 32'h200) begin errors++; $display("FAIL kill_target got %h want 00000200", FetchAddr); end
      end
      if (k == 37) begin
        checks++;
        if (IfValid !== 1'b0) begin errors++; $display("FAIL kill_drop got %b %h want 0", IfValid, IfPc); end
      end
      if (k == 38) begin
        checks++;
        if (IfValid !== 1'b1 || IfPc !== 32'h200 || IfInst !== word_of(32'h200)) begin
          errors++; $display("FAIL kill_head got %b %h %h want 1 00000200", IfValid, IfPc, IfInst);
        end
      end
      @(negedge clk);
    end
    CacheStall = 1'b0; RedirectValid = 1'b0;
  endtask

  task automatic test_async_wrap();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      CacheStall = (k >= 5);
      @(negedge clk);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (IfValid !== 1'b0 || IfPc !== 32'h0 || IfInst !== 32'h0 || FetchAddr !== 32'h0) begin
      errors++; $display("FAIL async_reset got %b %h %h %h want 0 0 0 0", IfValid, IfPc, IfInst, FetchAddr);
    end
    CacheStall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      RedirectValid = (k == 0);
      RedirectPc    = 32'hFFFF_FFFC;
      #1;
      if (k == 1) begin
        checks++;
        if (FetchAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_issue got %h want fffffffc", FetchAddr); end
      end
      if (k == 2) begin
        checks++;
        if (FetchAddr !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h want 00000000", FetchAddr); end
      end
      if (k == 3) begin
        checks++;
        if (IfPc !== 32'hFFFF_FFFC || IfInst !== word_of(32'hFFFF_FFFC) || FetchAddr !== 32'h4) begin
          errors++; $display("FAIL wrap_head got %h %h %h want fffffffc 00000004", IfPc, IfInst, FetchAddr);
        end
      end
      if (k == 4) begin
        checks++;
        if (IfPc !== 32'h0 || IfValid !== 1'b1) begin errors++; $display("FAIL wrap_next got %h want 00000000", IfPc); end
      end
      @(negedge clk);
    end
    RedirectValid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (IfValid !== 1'b0 || IfPc !== 32'h0 || IfInst !== 32'h0 || FetchAddr !== 32'h0) begin
      errors++; $display("FAIL final_reset got %b %h %h %h want 0 0 0 0", IfValid, IfPc, IfInst, FetchAddr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_miss();
    test_redirect_full();
    test_redirect_kill();
    test_async_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
